// File: rtl/nios2_instr_data_ram_arbiter.sv
// Two-master round-robin arbiter in front of the single-port instruction/data RAM.
// Bounded hold-off keeps short bursts intact; read responses are steered back to the issuer.
module nios2_instr_data_ram_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam logic [2:0] HOLD_LIMIT = 3'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t     state_q, state_d;
  logic       rr_last_q, rr_last_d;
  logic [2:0] hold_cnt_q, hold_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;
  logic       sel_q, sel_d;

  logic req0, req1;
  logic own, req_own, req_oth;
  logic gnt_any, gnt_id;
  logic sel;

  always_comb begin
    req0       = m0_read | m0_write;
    req1       = m1_read | m1_write;
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    hold_cnt_d = hold_cnt_q;
    gnt_any    = 1'b0;
    gnt_id     = 1'b0;
    own        = (state_q == OWN1);
    req_own    = own ? req1 : req0;
    req_oth    = own ? req0 : req1;

    // Arbitration state is left untouched while a reset request is pending.
    if (reset_n && !reset_req) begin
      unique case (state_q)
        IDLE: begin
          if (req0 && (!req1 || rr_last_q)) begin
            gnt_any    = 1'b1;
            gnt_id     = 1'b0;
            state_d    = OWN0;
            hold_cnt_d = 3'd1;
          end else if (req1) begin
            gnt_any    = 1'b1;
            gnt_id     = 1'b1;
            state_d    = OWN1;
            hold_cnt_d = 3'd1;
          end
        end
        OWN0, OWN1: begin
          if (req_own && (!req_oth || hold_cnt_q < HOLD_LIMIT)) begin
            gnt_any    = 1'b1;
            gnt_id     = own;
            hold_cnt_d = (hold_cnt_q == 3'd7) ? 3'd7 : hold_cnt_q + 3'd1;
          end else begin
            rr_last_d = own;
            if (req_oth) begin
              gnt_any    = 1'b1;
              gnt_id     = ~own;
              state_d    = own ? OWN0 : OWN1;
              hold_cnt_d = 3'd1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Mux select holds its last value when idle so the RAM address/data stay stable.
    sel        = gnt_any ? gnt_id : sel_q;
    sel_d      = sel;
    rd_pend_d  = gnt_any & (gnt_id ? (m1_read & ~m1_write) : (m0_read & ~m0_write));
    rd_owner_d = gnt_id;

    ram_address    = sel ? m1_address    : m0_address;
    ram_byteenable = sel ? m1_byteenable : m0_byteenable;
    ram_writedata  = sel ? m1_writedata  : m0_writedata;
    ram_chipselect = gnt_any;
    ram_write      = gnt_any & (gnt_id ? m1_write : m0_write);

    m0_waitrequest   = ~(gnt_any & ~gnt_id);
    m1_waitrequest   = ~(gnt_any & gnt_id);
    m0_readdata      = ram_readdata;
    m1_readdata      = ram_readdata;
    m0_readdatavalid = reset_n & rd_pend_q & ~rd_owner_q;
    m1_readdatavalid = reset_n & rd_pend_q & rd_owner_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      hold_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      hold_cnt_q <= hold_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      sel_q      <= sel_d;
    end
  end

endmodule

// File: tb/tb_nios2_instr_data_ram_arbiter.sv
// Directed bench: instance A uses MAX_HOLD=4, instance B uses MAX_HOLD=1; both share master stimulus.
module tb_nios2_instr_data_ram_arbiter;

  logic        clk, reset_n, reset_req;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;

  logic        a_m0_wait, a_m0_rdv, a_m1_wait, a_m1_rdv, a_cs, a_we;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_wd, a_rdq;
  logic [15:0] a_addr;
  logic [3:0]  a_be;
  logic        b_m0_wait, b_m0_rdv, b_m1_wait, b_m1_rdv, b_cs, b_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_wd, b_rdq;
  logic [15:0] b_addr;
  logic [3:0]  b_be;

  logic [31:0] memA [0:4095];
  logic [31:0] memB [0:4095];

  int n_tests = 0;
  int n_fail  = 0;

  nios2_instr_data_ram_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_HOLD(4)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(a_m0_wait),
    .m0_readdata(a_m0_rdata), .m0_readdatavalid(a_m0_rdv),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(a_m1_wait),
    .m1_readdata(a_m1_rdata), .m1_readdatavalid(a_m1_rdv),
    .ram_address(a_addr), .ram_byteenable(a_be), .ram_chipselect(a_cs),
    .ram_write(a_we), .ram_writedata(a_wd), .ram_readdata(a_rdq)
  );

  nios2_instr_data_ram_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_HOLD(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(b_m0_wait),
    .m0_readdata(b_m0_rdata), .m0_readdatavalid(b_m0_rdv),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(b_m1_wait),
    .m1_readdata(b_m1_rdata), .m1_readdatavalid(b_m1_rdv),
    .ram_address(b_addr), .ram_byteenable(b_be), .ram_chipselect(b_cs),
    .ram_write(b_we), .ram_writedata(b_wd), .ram_readdata(b_rdq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: registered read, byte-masked write.
  always @(posedge clk) begin
    a_rdq <= memA[a_addr[11:0]];
    b_rdq <= memB[b_addr[11:0]];
    if (a_cs && a_we)
      for (int i = 0; i < 4; i++)
        if (a_be[i]) memA[a_addr[11:0]][8*i +: 8] = a_wd[8*i +: 8];
    if (b_cs && b_we)
      for (int j = 0; j < 4; j++)
        if (b_be[j]) memB[b_addr[11:0]][8*j +: 8] = b_wd[8*j +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int k, ga, gb, pa, pb;
  logic pv;

  initial begin
    for (int m = 0; m < 4096; m++) begin
      memA[m] = 32'h0;
      memB[m] = 32'h0;
    end
    memA[16'h10] = 32'hDEADBEEF;  memB[16'h10] = 32'hDEADBEEF;
    memA[16'h20] = 32'h20202020;  memB[16'h20] = 32'h20202020;
    memB[16'h100] = 32'hCAFEBABE;

    reset_n = 1'b0; reset_req = 1'b0;
    m0_address = 16'h0010; m0_byteenable = 4'hF; m0_read = 1'b1; m0_write = 1'b0; m0_writedata = '0;
    m1_address = 16'h0020; m1_byteenable = 4'hF; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;

    // Reset held 3 cycles with a pending m0 read
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1("rst_m0_wait", a_m0_wait, 1'b1);
      chk1("rst_m1_wait", a_m1_wait, 1'b1);
      chk1("rst_cs", a_cs, 1'b0);
      chk1("rst_we", a_we, 1'b0);
      chk1("rst_rdv0", a_m0_rdv, 1'b0);
      tick();
    end
    reset_n = 1'b1;

    // Single read of 0x0010
    @(negedge clk);
    chk1("rd_m0_wait", a_m0_wait, 1'b0);
    chk1("rd_cs", a_cs, 1'b1);
    chk1("rd_we", a_we, 1'b0);
    chk("rd_addr", 32'(a_addr), 32'h10);
    chk1("rd_m1_wait", a_m1_wait, 1'b1);
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    chk1("rd_rdv0", a_m0_rdv, 1'b1);
    chk("rd_data", a_m0_rdata, 32'hDEADBEEF);
    chk1("rd_rdv1", a_m1_rdv, 1'b0);
    chk1("rd_idle_cs", a_cs, 1'b0);
    tick();

    // Contention from reset, reset_req inserted after an m1 grant
    reset_n = 1'b0; m0_read = 1'b1; m1_read = 1'b1;
    tick();
    reset_n = 1'b1;
    k = 0; pv = 1'b0; pa = 0; pb = 0;
    for (int c = 0; c < 22; c++) begin
      reset_req = (c >= 14 && c < 19);
      ga = (k / 4) % 2;
      gb = k % 2;
      @(negedge clk);
      if (reset_req) begin
        chk1("rq_a_m0_wait", a_m0_wait, 1'b1);
        chk1("rq_a_m1_wait", a_m1_wait, 1'b1);
        chk1("rq_a_cs", a_cs, 1'b0);
        chk1("rq_b_cs", b_cs, 1'b0);
      end else begin
        chk1("ct_a_m0_wait", a_m0_wait, ga != 0);
        chk1("ct_a_m1_wait", a_m1_wait, ga != 1);
        chk1("ct_a_cs", a_cs, 1'b1);
        chk("ct_a_addr", 32'(a_addr), (ga != 0) ? 32'h20 : 32'h10);
        chk1("ct_b_m0_wait", b_m0_wait, gb != 0);
        chk1("ct_b_m1_wait", b_m1_wait, gb != 1);
        chk("ct_b_addr", 32'(b_addr), (gb != 0) ? 32'h20 : 32'h10);
      end
      chk1("ct_a_rdv0", a_m0_rdv, pv && pa == 0);
      chk1("ct_a_rdv1", a_m1_rdv, pv && pa == 1);
      chk1("ct_b_rdv0", b_m0_rdv, pv && pb == 0);
      chk1("ct_b_rdv1", b_m1_rdv, pv && pb == 1);
      if (pv) begin
        chk("ct_a_data", a_m0_rdata, (pa != 0) ? 32'h20202020 : 32'hDEADBEEF);
        chk("ct_b_data", b_m1_rdata, (pb != 0) ? 32'h20202020 : 32'hDEADBEEF);
      end
      pv = !reset_req;
      pa = ga;
      pb = gb;
      if (!reset_req) k++;
      tick();
    end
    reset_req = 1'b0; m0_read = 1'b0; m1_read = 1'b0;
    tick();

    // MAX_HOLD=1: masked m0 write against m1 read of the same word
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m0_write = 1'b1; m0_address = 16'h0100; m0_byteenable = 4'h3; m0_writedata = 32'h11223344;
    m1_read = 1'b1; m1_address = 16'h0100;
    @(negedge clk);
    chk1("mx0_b_m0_wait", b_m0_wait, 1'b0);
    chk1("mx0_b_m1_wait", b_m1_wait, 1'b1);
    chk1("mx0_b_we", b_we, 1'b1);
    chk("mx0_b_be", 32'(b_be), 32'h3);
    chk("mx0_b_wd", b_wd, 32'h11223344);
    chk("mx0_b_addr", 32'(b_addr), 32'h100);
    tick();
    @(negedge clk);
    chk1("mx1_b_m1_wait", b_m1_wait, 1'b0);
    chk1("mx1_b_m0_wait", b_m0_wait, 1'b1);
    chk1("mx1_b_we", b_we, 1'b0);
    chk1("mx1_b_cs", b_cs, 1'b1);
    chk1("mx1_a_m1_wait", a_m1_wait, 1'b1);
    tick();
    m1_read = 1'b0;
    @(negedge clk);
    chk1("mx2_b_m0_wait", b_m0_wait, 1'b0);
    chk1("mx2_b_rdv1", b_m1_rdv, 1'b1);
    chk("mx2_b_data", b_m1_rdata, 32'hCAFE3344);
    chk1("mx2_b_rdv0", b_m0_rdv, 1'b0);
    tick();
    m0_write = 1'b0; m0_byteenable = 4'hF;
    tick();

    // Read and write together on m0: write wins, no response
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 16'h0200; m0_writedata = 32'hA5A5A5A5;
    @(negedge clk);
    chk1("rw_m0_wait", a_m0_wait, 1'b0);
    chk1("rw_we", a_we, 1'b1);
    chk("rw_wd", a_wd, 32'hA5A5A5A5);
    tick();
    m0_read = 1'b0; m0_write = 1'b0;
    @(negedge clk);
    chk1("rw_no_rdv0", a_m0_rdv, 1'b0);
    chk1("rw_no_rdv1", a_m1_rdv, 1'b0);
    tick();
    m0_read = 1'b1;
    @(negedge clk);
    chk1("rw_rd_wait", a_m0_wait, 1'b0);
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    chk1("rw_rd_rdv", a_m0_rdv, 1'b1);
    chk("rw_rd_data", a_m0_rdata, 32'hA5A5A5A5);
    tick();

    // Reset in the cycle after a read grant drops the response
    m0_read = 1'b1; m0_address = 16'h0010;
    @(negedge clk);
    chk1("rd_drop_wait", a_m0_wait, 1'b0);
    tick();
    m0_read = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    chk1("rd_drop_rdv", a_m0_rdv, 1'b0);
    chk1("rd_drop_cs", a_cs, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_instr_data_ram_arbiter.md
Name: nios2_instr_data_ram_arbiter

Overview:
- Two-master Avalon-MM arbiter in front of the single-port 51200x32 on-chip instruction/data RAM.
- Shares the one RAM port between master 0 (Nios II data master) and master 1 (DMA/host bridge).
- Uses round-robin arbitration with a bounded hold-off so short bursts are not broken up.
- Tracks the 1-cycle RAM read latency and steers readdatavalid back to the issuing master.

Parameters:
- ADDR_W, 16, word address width, matches the RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_HOLD, 4, maximum consecutive grants to one master while the other master is requesting; legal range 1..7; 1 gives strict alternation.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- reset_req  in  1  system reset request; while high, no RAM access is issued.
- m0_address  in  ADDR_W  master 0 word address.
- m0_byteenable  in  DATA_W/8  master 0 byte enables.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  high = master 0 transfer not accepted this cycle.
- m0_readdata  out  DATA_W  read data to master 0.
- m0_readdatavalid  out  1  qualifies m0_readdata.
- m1_*  same set as m0_*, for master 1.
- ram_address  out  ADDR_W  to RAM address.
- ram_byteenable  out  DATA_W/8  to RAM byteenable.
- ram_chipselect  out  1  to RAM chipselect.
- ram_write  out  1  to RAM write.
- ram_writedata  out  DATA_W  to RAM writedata.
- ram_readdata  in  DATA_W  from RAM (unregistered q; valid the cycle after address).

Behaviour:
- Request: reqN = mN_read | mN_write.
- Grant is combinational from the registered state plus the current requests.
  - The granted master sees waitrequest=0; the transfer completes that cycle.
  - The non-granted master sees waitrequest=1.
- RAM command: ram_address, ram_byteenable and ram_writedata are muxed from the granted master.
  - ram_chipselect = any grant.
  - ram_write = granted master's write.
  - With no grant: ram_chipselect=0, ram_write=0; address/data are don't-care but must be held stable (mux select does not change).
- If read and write are asserted together: the write is performed and no readdatavalid is generated.
- State machine, states IDLE, OWN0, OWN1; registered rr_last (last owner) and hold_cnt (3 bits):
  - IDLE, one requester: grant it, go to OWNx, hold_cnt=1.
  - IDLE, both requesting: grant the master != rr_last, go to OWNx, hold_cnt=1.
  - IDLE, no request: stay in IDLE.
  - OWNx, reqx=1 and (other idle or hold_cnt<MAX_HOLD): grant x; hold_cnt=min(hold_cnt+1,7).
  - OWNx, otherwise, other requesting: grant the other, go to OWNother, hold_cnt=1, rr_last=x.
  - OWNx, no requests: go to IDLE, rr_last=x.
- Read tracking:
  - A granted read in cycle t sets rd_pend (and records the owner) for cycle t+1.
  - In cycle t+1, owner's readdatavalid=1 for exactly one cycle.
  - m0_readdata = m1_readdata = ram_readdata (broadcast; only readdatavalid is steered).
  - Back-to-back reads, one per cycle, are sustained with no bubble, including across an owner switch.
- Writes complete with zero wait states and produce no response.
- reset_req=1:
  - No grants; both waitrequest=1; ram_chipselect=0.
  - State, rr_last and hold_cnt are frozen.
  - A read granted in the cycle before reset_req rose is still returned (readdatavalid pulse in the following cycle).
- reset_n=0, sampled on the clk edge:
  - State=IDLE, rr_last=1 (so master 0 wins the first tie), hold_cnt=0, rd_pend=0.
  - While reset_n is low, outputs are forced: both waitrequest=1, both readdatavalid=0, ram_chipselect=0, ram_write=0.
  - Reset in the cycle after a read grant drops that read's readdatavalid.

Test Plan:
- Reset: reset_n low 3 cycles with m0_read=1 -> waitrequest=1 and ram_chipselect=0 throughout; first cycle after release: m0 granted, ram_address=m0_address.
- Single read: m0 reads addr 0x0010 (RAM holds 0xDEADBEEF) -> cycle t: m0_waitrequest=0, ram_chipselect=1, ram_write=0; t+1: m0_readdatavalid=1, m0_readdata=0xDEADBEEF; m1_readdatavalid=0.
- Contention, MAX_HOLD=4: both masters read continuously from reset -> grant sequence m0,m0,m0,m0,m1,m1,m1,m1,m0...; 100% RAM utilisation; each readdatavalid lands 1 cycle after the corresponding grant.
- MAX_HOLD=1 with mixed traffic: m0 writes 0x11223344 to 0x0100 with byteenable 0x3 while m1 reads 0x0100 -> strict alternation; m1's read after the write returns 0x????3344 (upper bytes unchanged from prior value).
- reset_req: assert for 5 cycles mid-contention, one cycle after an m1 read grant -> m1_readdatavalid still pulses once; no grants for 5 cycles; after deassert, arbitration resumes with the same owner and hold_cnt.
- Read+write together: m0_read=m0_write=1, addr 0x0200, data 0xA5A5A5A5 -> RAM write occurs, no m0_readdatavalid; a later read of 0x0200 returns 0xA5A5A5A5.
